// File: rtl/module_frequency_divider.sv
// module_frequency_divider
//
// Programmable clock divider. clk_out is a registered square wave whose
// half-period is `period` clk_in cycles, so the full period is 2*period.
// A period of 0 halts the divider with clk_out held low.
//
// The requested period is copied into an active register (act) only while
// idle or at the end of a half-period. A new value therefore takes effect
// at the next toggle and never shortens or stretches a half-period that is
// already in progress.
//
// Optional build macro:
//   FREQDIV_TICK_EN  adds the tick output, a registered one-cycle strobe
//                    that is high in the first clk_in cycle after each
//                    clk_out rising transition.
//
// Ports:
//   clk_in   in   1   sole clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   period   in   30  half-period of clk_out in clk_in cycles, 0 = halt
//   clk_out  out  1   divided clock, driven straight from a flop
//   tick     out  1   rise strobe (FREQDIV_TICK_EN builds only)
`timescale 1ns/1ps

module module_frequency_divider (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic [29:0] period,
`ifdef FREQDIV_TICK_EN
    output logic        tick,
`endif
    output logic        clk_out
);

    logic [29:0] cnt;
    logic [29:0] act;

    logic idle;
    logic terminal;
    logic period_zero;

    // act == 0 is the idle condition; no separate state bit is kept.
    assign idle        = (act == 30'd0);
    // act - 1 cannot underflow here because terminal is gated by !idle.
    assign terminal    = !idle && (cnt == (act - 30'd1));
    assign period_zero = (period == 30'd0);

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 30'd0;
            act     <= 30'd0;
            clk_out <= 1'b0;
        end else if (idle) begin
            act     <= period;
            cnt     <= 30'd0;
            clk_out <= 1'b0;
        end else if (terminal) begin
            cnt     <= 30'd0;
            act     <= period;
            // Halting always parks the output low rather than mid-level.
            clk_out <= period_zero ? 1'b0 : ~clk_out;
        end else begin
            cnt     <= cnt + 30'd1;
        end
    end

`ifdef FREQDIV_TICK_EN
    // Fires on the same edge that raises clk_out, so the strobe is aligned
    // with the first high cycle of clk_out.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            tick <= 1'b0;
        end else begin
            tick <= terminal && !clk_out && !period_zero;
        end
    end
`endif

endmodule

// File: tb/tb_module_frequency_divider.sv
`timescale 1ns/1ps

module tb_module_frequency_divider;

    logic        clk_in;
    logic        rst_n;
    logic [29:0] period;
    logic        clk_out;
`ifdef FREQDIV_TICK_EN
    logic        tick;
`endif

    int checks;
    int errors;
    realtime t_rise_a;
    realtime t_rise_b;
    realtime t_fall;

    module_frequency_divider dut (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .period  (period),
`ifdef FREQDIV_TICK_EN
        .tick    (tick),
`endif
        .clk_out (clk_out)
    );

    initial clk_in = 1'b0;
    always #20 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then sample 1 ns after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // Hold reset over a couple of edges, then release on a falling edge so
    // the next rising edge is edge 1.
    task automatic do_reset(input logic [29:0] p);
        rst_n  = 1'b0;
        period = p;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        period = 30'd0;
        #5;
        chk("reset_clk_out", {31'd0, clk_out}, 32'd0);
`ifdef FREQDIV_TICK_EN
        chk("reset_tick", {31'd0, tick}, 32'd0);
`endif

        // period = 1000: rise at edge 1001, 80 us period, 50% duty
        do_reset(30'd1000);
        chk("p1000_release", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("p1000_e1", {31'd0, clk_out}, 32'd0);
        step(999);
        chk("p1000_e1000", {31'd0, clk_out}, 32'd0);
        step(1);
        t_rise_a = $realtime;
        chk("p1000_e1001", {31'd0, clk_out}, 32'd1);
`ifdef FREQDIV_TICK_EN
        chk("p1000_tick_e1001", {31'd0, tick}, 32'd1);
        step(1);
        chk("p1000_tick_e1002", {31'd0, tick}, 32'd0);
        step(998);
`else
        step(999);
`endif
        chk("p1000_e2000", {31'd0, clk_out}, 32'd1);
        step(1);
        t_fall = $realtime;
        chk("p1000_e2001", {31'd0, clk_out}, 32'd0);
        step(1000);
        t_rise_b = $realtime;
        chk("p1000_e3001", {31'd0, clk_out}, 32'd1);
        chk("p1000_period_ns", 32'(int'(t_rise_b - t_rise_a)), 32'd80000);
        chk("p1000_high_ns", 32'(int'(t_fall - t_rise_a)), 32'd40000);

        // period = 1: toggles every edge from edge 2
        do_reset(30'd1);
        step(1);
        chk("p1_e1", {31'd0, clk_out}, 32'd0);
        for (int i = 2; i <= 7; i++) begin
            step(1);
            chk("p1_toggle", {31'd0, clk_out}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // period = 3: rise 4, fall 7, rise 10
        do_reset(30'd3);
        step(3);
        chk("p3_e3", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("p3_e4", {31'd0, clk_out}, 32'd1);
        step(2);
        chk("p3_e6", {31'd0, clk_out}, 32'd1);
        step(1);
        chk("p3_e7", {31'd0, clk_out}, 32'd0);
        step(2);
        chk("p3_e9", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("p3_e10", {31'd0, clk_out}, 32'd1);

        // period = 0 stays low; then period = 5 rises 5 edges after load
        do_reset(30'd0);
        for (int i = 0; i < 4; i++) begin
            step(5);
            chk("p0_halt", {31'd0, clk_out}, 32'd0);
        end
        period = 30'd5;
        step(1);
        chk("p5_load", {31'd0, clk_out}, 32'd0);
        step(4);
        chk("p5_load_plus4", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("p5_load_plus5", {31'd0, clk_out}, 32'd1);

        // period 4 -> 2 mid-half-period, then 2 -> 0 while running
        do_reset(30'd4);
        step(5);
        chk("p4_e5", {31'd0, clk_out}, 32'd1);
        step(1);
        period = 30'd2;
        step(2);
        chk("p4to2_e8", {31'd0, clk_out}, 32'd1);
        step(1);
        chk("p4to2_e9", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("p4to2_e10", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("p4to2_e11", {31'd0, clk_out}, 32'd1);
        step(1);
        chk("p4to2_e12", {31'd0, clk_out}, 32'd1);
        step(1);
        chk("p4to2_e13", {31'd0, clk_out}, 32'd0);
        period = 30'd0;
        step(2);
        chk("p2to0_e15", {31'd0, clk_out}, 32'd0);
        step(10);
        chk("p2to0_e25", {31'd0, clk_out}, 32'd0);

        // async reset during the high phase
        do_reset(30'd3);
        step(5);
        chk("rst_mid_high_pre", {31'd0, clk_out}, 32'd1);
        #5;
        rst_n = 1'b0;
        #1;
        chk("rst_async_drop", {31'd0, clk_out}, 32'd0);
        @(negedge clk_in);
        rst_n = 1'b1;
        #1;
        chk("rst_release", {31'd0, clk_out}, 32'd0);
        step(3);
        chk("rst_restart_e3", {31'd0, clk_out}, 32'd0);
        step(1);
        chk("rst_restart_e4", {31'd0, clk_out}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/module_frequency_divider.md
MODULE_FREQUENCY_DIVIDER -- requirements
Module: module_frequency_divider

Interface
REQ-001 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 period  input  30  half-period of clk_out in clk_in cycles, unsigned; 0 = halt.
REQ-004 clk_out  output  1  divided clock, registered; full period = 2*period clk_in cycles.
REQ-005 tick  output  1  one-cycle strobe on each clk_out rising transition; present only with FREQDIV_TICK_EN.

Function
REQ-006 Internal state SHALL be a 30-bit counter cnt, a 30-bit active-period register act and the clk_out flop; no other state is permitted.
- act is the shadow copy of period.
REQ-007 Idle (act==0) SHALL, per edge: act<=period, cnt<=0, clk_out<=0.
REQ-008 Run (act!=0), cnt!=act-1 SHALL, per edge: cnt<=cnt+1; clk_out and act unchanged.
REQ-009 Run, cnt==act-1 (terminal) SHALL, per edge: cnt<=0, act<=period, clk_out<=~clk_out.
- Exception: if the newly sampled period is 0, clk_out<=0.
REQ-010 period SHALL be sampled only in idle or at terminal; changes between samples take effect at the next toggle, never mid-half-period.
REQ-011 Latency: reset released, period=P>0 stable, edge 1 loads act.
- clk_out rises on edge P+1 after release, then toggles every P edges.
REQ-012 P=1 SHALL give clk_out = clk_in/2, toggling on every edge in run.
REQ-013 P=2^30-1 SHALL work without overflow; cnt never exceeds act-1.
REQ-014 period->0 while running SHALL force clk_out low at the next terminal and enter idle.
REQ-015 Idle->nonzero SHALL restart per REQ-011 timing, counted from the load edge.
REQ-016 clk_out SHALL be driven directly from a flop; no combinational gating, glitch-free.

Reset
REQ-017 rst_n low SHALL immediately, without a clock, force cnt=0, act=0, clk_out=0, and tick=0 when present.
REQ-018 Reset asserted mid-half-period SHALL discard progress.
- After release, behaviour is exactly REQ-011 from edge 1.
REQ-019 Reset release SHALL be synchronous to clk_in; no output changes on the release itself.

Configuration
REQ-020 Macro FREQDIV_TICK_EN defined: port tick exists.
- tick is registered and high for exactly the one clk_in cycle in which clk_out has just gone 0->1; low otherwise.
REQ-021 FREQDIV_TICK_EN undefined: port tick and its logic are absent.
- clk_out behaviour is identical in both builds.

Verification
REQ-022 Verification SHALL cover the following directed scenarios:
- 40 ns clk_in, period=1000, reset released -> clk_out rises at edge 1001; measured period 80 us, 50% duty; tick (if built) one 40 ns pulse per rise.
- period=1 -> clk_out toggles every edge from edge 2; frequency clk_in/2.
- period=3 -> rise at edge 4, fall at 7, rise at 10; 6-cycle period.
- period=0 -> clk_out stays 0 indefinitely; then period=5 -> first rise 5 edges after load edge.
- Running at period=4, change to 2 mid-half-period -> current half-period completes at 4 cycles; following half-periods are 2 cycles.
- rst_n pulsed low mid-high phase -> clk_out drops to 0 without a clock edge; after release, timing restarts per REQ-011.
